// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX-side arbitration logic.
package uart_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   // Default link settings; blocks may override via their own parameters
   localparam int DEF_CLK_FREQ  = 1000000;
   localparam int DEF_BAUD_RATE = 9600;
   localparam int CLKS_PER_BIT  = DEF_CLK_FREQ / DEF_BAUD_RATE;

   // Widest requester vector the helpers handle
   localparam int MAX_REQ = 8;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } rr_pick_t;

   // Round-robin pick: first set bit of req scanning upward from ptr,
   // wrapping at n_req-1 -> 0. Iterating the offsets from high to low lets
   // the smallest offset overwrite the result last, so it wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         ptr,
                                        input int                 n_req);
      rr_pick_t p;
      int       k;
      p = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n_req) begin
            k = (int'(ptr) + i) % n_req;
            if (req[k[2:0]]) begin
               p.valid = 1'b1;
               p.idx   = k[2:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: combinational pick over the request vector plus a
// registered priority pointer that moves past the last served requester.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_adv,
   input  logic [2:0]       i_last,
   output logic             o_valid,
   output logic [2:0]       o_sel
);

   localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

   logic [2:0]         r_ptr;
   logic [MAX_REQ-1:0] w_req8;
   rr_pick_t           w_pick;

   // Widen the request vector to the helper's fixed width and pick a winner
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      w_req8              = '0;
      w_req8[N_REQ-1:0]   = i_req;
      w_pick              = rr_pick(w_req8, r_ptr, N_REQ);
   end

   assign o_valid = w_pick.valid;
   assign o_sel   = w_pick.idx;

   // Priority pointer: after a transaction ends, start the next scan just
   // past the requester that was served (or aborted)
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (i_last == LAST_IDX) ? 3'd0 : i_last + 3'd1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers with round-robin
// fairness: grant, strobe newd/dintx, wait for frame done, acknowledge.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD_RATE = DEF_BAUD_RATE,
   parameter int NEWD_HOLD = CLK_FREQ / BAUD_RATE,
   parameter int TIMEOUT   = 16 * (CLK_FREQ / BAUD_RATE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic               newd,
   output logic [7:0]         dintx,
   input  logic               donetx,
   output logic               busy,
   output logic [2:0]         cur_id,
   output logic               timeout_err
);

   localparam int             CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(NEWD_HOLD - 1);
   localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);

   if (NEWD_HOLD >= TIMEOUT || N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_cfg
      $error("uart_tx_arbiter: need NEWD_HOLD < TIMEOUT and 2 <= N_REQ <= 8");
   end

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [CW-1:0]     r_hold_cnt;
   logic [CW-1:0]     r_to_cnt;
   logic              r_donetx_q;
   logic              r_done_seen;
   logic              r_newd;
   logic [7:0]        r_dintx;
   logic [2:0]        r_cur_id;
   logic [N_REQ-1:0]  r_ack;
   logic              r_timeout_err;

   logic              w_valid;
   logic [2:0]        w_sel;
   logic [7:0]        w_sel_byte;
   logic [N_REQ-1:0]  w_ack_vec;
   logic              w_done_rise;
   logic              w_grant;
   logic              w_done_ok;
   logic              w_abort;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .i_req   (req),
      .i_adv   (w_done_ok | w_abort),
      .i_last  (r_cur_id),
      .o_valid (w_valid),
      .o_sel   (w_sel)
   );

   assign w_done_rise = donetx & ~r_donetx_q;

   // Byte mux for the selected requester and one-hot ack for the granted one
   always_comb begin
      w_sel_byte = '0;
      w_ack_vec  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_sel == 3'(i))    w_sel_byte   = req_data[8*i +: 8];
         if (r_cur_id == 3'(i)) w_ack_vec[i] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and transaction events; a done edge beats a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_done_ok   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_grant     = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (r_hold_cnt == HOLD_LAST) w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (r_done_seen || w_done_rise) begin
               w_done_ok   = 1'b1;
               w_state_nxt = IDLE;
            end else if (r_to_cnt == TO_LAST) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: grant capture, newd hold window, timeout count, done capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt    <= '0;
         r_to_cnt      <= '0;
         r_donetx_q    <= 1'b0;
         r_done_seen   <= 1'b0;
         r_newd        <= 1'b0;
         r_dintx       <= 8'h00;
         r_cur_id      <= 3'd0;
         r_ack         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_donetx_q    <= donetx;
         r_ack         <= '0;
         r_timeout_err <= 1'b0;

         if (w_grant) begin
            r_dintx     <= w_sel_byte;
            r_cur_id    <= w_sel;
            r_newd      <= 1'b1;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_done_seen <= 1'b0;
         end else if (r_state != IDLE) begin
            r_to_cnt <= r_to_cnt + CW'(1);
         end

         // A frame may finish while newd is still held; remember it
         if (r_state == HOLD) begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
            if (w_done_rise)              r_done_seen <= 1'b1;
            if (r_hold_cnt == HOLD_LAST)  r_newd      <= 1'b0;
         end

         if (w_done_ok) r_ack <= w_ack_vec;

         if (w_abort) begin
            r_timeout_err <= 1'b1;
            r_newd        <= 1'b0;
         end
      end
   end

   assign ack         = r_ack;
   assign newd        = r_newd;
   assign dintx       = r_dintx;
   assign cur_id      = r_cur_id;
   assign timeout_err = r_timeout_err;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
// Small clock/baud values give NEWD_HOLD = 4 and TIMEOUT = 64 clocks.
module tb_uart_tx_arbiter;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 64;
   localparam int FRAME   = 20;   // clks from newd rise to donetx rise in model

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic               newd;
   logic [7:0]         dintx;
   logic               donetx;
   logic               busy;
   logic [2:0]         cur_id;
   logic               timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Transmitter model state
   logic       tx_en;
   logic       newd_prev;
   int         frame_cnt;
   int         done_hold;
   int         ack_total;
   logic [7:0] tx_log[$];

   uart_tx_arbiter #(
      .N_REQ     (N_REQ),
      .CLK_FREQ  (40),
      .BAUD_RATE (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .newd        (newd),
      .dintx       (dintx),
      .donetx      (donetx),
      .busy        (busy),
      .cur_id      (cur_id),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a nonzero ack at a falling edge; returns 0 on expiry
   task automatic wait_ack(output logic [N_REQ-1:0] a);
      a = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ack != '0) begin
            a = ack;
            return;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Transmitter model and ack monitor: on a newd rise it logs dintx and,
   // FRAME clks later (if enabled), raises donetx for two clocks
   initial begin
      donetx    = 1'b0;
      newd_prev = 1'b0;
      frame_cnt = 0;
      done_hold = 0;
      ack_total = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            donetx    = 1'b0;
            frame_cnt = 0;
            done_hold = 0;
            newd_prev = 1'b0;
         end else begin
            if (ack != '0) ack_total++;
            if (done_hold > 0) begin
               done_hold--;
               if (done_hold == 0) donetx = 1'b0;
            end
            if (newd && !newd_prev) begin
               tx_log.push_back(dintx);
               frame_cnt = FRAME;
            end else if (frame_cnt > 0) begin
               frame_cnt--;
               if (frame_cnt == 0 && tx_en) begin
                  donetx    = 1'b1;
                  done_hold = 2;
               end
            end
            newd_prev = newd;
         end
      end
   end

   initial begin
      logic [N_REQ-1:0] a;
      logic [7:0]       exp_bytes[5];
      logic [3:0]       exp_acks[5];
      int               cyc;
      int               acks_before;
      logic             saw_ack;

      rst      = 1'b1;
      req      = '0;
      req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      tx_en    = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_ack",    32'(ack), 32'h0);
      check("rst_newd",   32'(newd), 32'h0);
      check("rst_dintx",  32'(dintx), 32'h00);
      check("rst_busy",   32'(busy), 32'h0);
      check("rst_cur_id", 32'(cur_id), 32'h0);
      check("rst_tmo",    32'(timeout_err), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single requester 2
      req = 4'b0100;
      @(negedge clk);
      check("t1_newd",   32'(newd), 32'h1);
      check("t1_dintx",  32'(dintx), 32'hA5);
      check("t1_cur_id", 32'(cur_id), 32'h2);
      check("t1_busy",   32'(busy), 32'h1);
      wait_ack(a);
      req = '0;
      check("t1_ack",      32'(a), 32'h4);
      check("t1_busy_ack", 32'(busy), 32'h0);
      @(negedge clk);
      check("t1_ack_one",  32'(ack), 32'h0);
      check("t1_busy_nxt", 32'(busy), 32'h0);

      // All four requesting: fair rotation 0,1,2,3,0
      do_reset();
      tx_log.delete();
      req_data     = {8'h44, 8'h33, 8'h22, 8'h11};
      exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
      exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h11;
      exp_acks[0]  = 4'b0001; exp_acks[1] = 4'b0010; exp_acks[2] = 4'b0100;
      exp_acks[3]  = 4'b1000; exp_acks[4] = 4'b0001;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(a);
         if (k == 4) req = '0;
         check($sformatf("t2_ack%0d", k), 32'(a), 32'(exp_acks[k]));
      end
      check("t2_frames", 32'(tx_log.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < tx_log.size())
            check($sformatf("t2_byte%0d", k), 32'(tx_log[k]), 32'(exp_bytes[k]));
         else
            check($sformatf("t2_byte%0d", k), 32'hFFFF_FFFF, 32'(exp_bytes[k]));
      end

      // Pointer wrap: after serving 1 (ptr=2), req 0011 grants 0 then 1
      do_reset();
      req = 4'b0010;
      wait_ack(a);
      check("t3_ack1", 32'(a), 32'h2);
      req = 4'b0011;
      @(negedge clk);
      check("t3_newd",  32'(newd), 32'h1);
      check("t3_cur0",  32'(cur_id), 32'h0);
      wait_ack(a);
      req = 4'b0010;
      check("t3_ack0", 32'(a), 32'h1);
      wait_ack(a);
      req = '0;
      check("t3_ack1b", 32'(a), 32'h2);

      // Timeout with donetx held low
      do_reset();
      tx_en   = 1'b0;
      saw_ack = 1'b0;
      req     = 4'b0010;
      @(negedge clk);
      check("t4_newd", 32'(newd), 32'h1);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) saw_ack = 1'b1;
         if (timeout_err) break;
      end
      check("t4_tmo_cycles", 32'(cyc), 32'(TIMEOUT));
      check("t4_no_ack",     32'(saw_ack), 32'h0);
      check("t4_newd_low",   32'(newd), 32'h0);
      @(negedge clk);
      check("t4_regrant",    32'(newd), 32'h1);
      check("t4_regrant_id", 32'(cur_id), 32'h1);
      check("t4_tmo_pulse",  32'(timeout_err), 32'h0);
      tx_en = 1'b1;
      wait_ack(a);
      req = '0;
      check("t4_ack", 32'(a), 32'h2);

      // Reset asserted in WAIT_DONE
      do_reset();
      req = 4'b1000;
      @(negedge clk);
      repeat (7) @(negedge clk);
      check("t5_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1;
      req = '0;
      #1;
      check("t5_newd_async", 32'(newd), 32'h0);
      check("t5_busy_async", 32'(busy), 32'h0);
      check("t5_ack_async",  32'(ack), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      acks_before = ack_total;
      repeat (40) @(negedge clk);
      check("t5_no_ack", 32'(ack_total - acks_before), 32'h0);
      req = 4'b1000;
      @(negedge clk);
      check("t5_cur3", 32'(cur_id), 32'h3);
      wait_ack(a);
      req = '0;
      check("t5_ack3", 32'(a), 32'h8);

      // Request dropped during HOLD still completes once
      do_reset();
      req = 4'b0001;
      @(negedge clk);
      req = '0;
      acks_before = ack_total;
      wait_ack(a);
      check("t6_ack0", 32'(a), 32'h1);
      @(negedge clk);
      check("t6_idle", 32'(busy), 32'h0);
      repeat (30) @(negedge clk);
      check("t6_ack_once", 32'(ack_total - acks_before), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
